// File: rtl/dsp_div_recover_if.sv
// Start/done handshake plus operand and result bus for the DSP-inverse divider.
interface dsp_div_recover_if;
  localparam int unsigned DW = 48;
  localparam int unsigned BW = 18;

  logic          start;
  logic [DW-1:0] P;
  logic [DW-1:0] C;
  logic [BW-1:0] B;
  logic          busy;
  logic          done;
  logic [DW-1:0] Q;
  logic [BW-1:0] R;
  logic          dz;

  modport master (
    output start, P, C, B,
    input  busy, done, Q, R, dz
  );

  modport slave (
    input  start, P, C, B,
    output busy, done, Q, R, dz
  );
endinterface

// File: rtl/dsp_div_recover.sv
// Restoring divider that recovers the A-side operand of a DSP multiply-add:
// Q = diff / B, R = diff % B, with diff = P - C (ADD) or P + C (SUBTRACT).
// One quotient bit per cycle, one transaction in flight.
module dsp_div_recover #(
  parameter string OPERATION = "ADD"
) (
  input  logic           clk,
  input  logic           rst,
  dsp_div_recover_if.slave bus
);
  localparam int unsigned DW     = 48;
  localparam int unsigned BW     = 18;
  localparam int unsigned CW     = 6;
  localparam logic [CW-1:0] LAST = CW'(DW - 1);
  localparam logic IS_SUB        = (OPERATION == "SUBTRACT");

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    DZERO = 2'd2
  } state_t;

  state_t        state;
  logic [DW-1:0] dvd;
  logic [BW-1:0] div;
  logic [BW:0]   rem;
  logic [CW-1:0] cnt;
  logic          busy_reg;
  logic          done_reg;
  logic [DW-1:0] quo;
  logic [BW-1:0] rmd;
  logic          dz_reg;

  logic [DW-1:0] diff_c;
  logic [BW+1:0] trial_c;
  logic          qbit_c;
  logic [BW:0]   rem_nxt_c;
  logic [DW-1:0] dvd_nxt_c;

  // Undo the DSP add/subtract; wraps modulo 2^48.
  always_comb begin
    diff_c = IS_SUB ? (bus.P + bus.C) : (bus.P - bus.C);
  end

  // One restoring step: shift in the next dividend bit and try subtracting the divisor.
  // The extra top bit of trial_c is the sign; rem's guard bit is always zero here.
  always_comb begin
    trial_c   = {rem, dvd[DW-1]} - {2'b00, div};
    qbit_c    = ~trial_c[BW+1];
    rem_nxt_c = qbit_c ? trial_c[BW:0] : {rem[BW-1:0], dvd[DW-1]};
    dvd_nxt_c = {dvd[DW-2:0], qbit_c};
  end

  // Control FSM, iteration registers and registered results.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      dvd      <= '0;
      div      <= '0;
      rem      <= '0;
      cnt      <= '0;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
      quo      <= '0;
      rmd      <= '0;
      dz_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            dvd      <= diff_c;
            div      <= bus.B;
            rem      <= '0;
            cnt      <= '0;
            busy_reg <= 1'b1;
            state    <= (bus.B != '0) ? CALC : DZERO;
          end
        end
        CALC: begin
          dvd <= dvd_nxt_c;
          rem <= rem_nxt_c;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            quo      <= dvd_nxt_c;
            rmd      <= rem_nxt_c[BW-1:0];
            dz_reg   <= 1'b0;
            done_reg <= 1'b1;
            busy_reg <= 1'b0;
            state    <= IDLE;
          end
        end
        DZERO: begin
          quo      <= '1;
          rmd      <= '0;
          dz_reg   <= 1'b1;
          done_reg <= 1'b1;
          busy_reg <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          busy_reg <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_reg;
  assign bus.done = done_reg;
  assign bus.Q    = quo;
  assign bus.R    = rmd;
  assign bus.dz   = dz_reg;
endmodule

// File: tb/tb_dsp_div_recover.sv
// Directed bench for dsp_div_recover: ADD and SUBTRACT builds share one stimulus.
module tb_dsp_div_recover;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  dsp_div_recover_if bus_a ();
  dsp_div_recover_if bus_s ();

  dsp_div_recover #(.OPERATION("ADD")) dut_add (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  dsp_div_recover #(.OPERATION("SUBTRACT")) dut_sub (
    .clk (clk),
    .rst (rst),
    .bus (bus_s.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive the same inputs onto both builds.
  task automatic drive(input logic s, input logic [47:0] p, input logic [47:0] c, input logic [17:0] b);
    bus_a.start = s; bus_a.P = p; bus_a.C = c; bus_a.B = b;
    bus_s.start = s; bus_s.P = p; bus_s.C = c; bus_s.B = b;
  endtask

  task automatic set_start(input logic s);
    bus_a.start = s;
    bus_s.start = s;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    set_start(1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Pulse start for one edge; returns at the negedge right after the capture edge.
  task automatic launch(input logic [47:0] p, input logic [47:0] c, input logic [17:0] b);
    @(negedge clk);
    drive(1'b1, p, c, b);
    @(negedge clk);
    set_start(1'b0);
  endtask

  // Count negedges after the capture edge until done, bounded.
  task automatic wait_done(output int cyc, output int busy_n);
    cyc = 0;
    busy_n = 0;
    while (bus_a.done !== 1'b1 && cyc < 80) begin
      if (bus_a.busy === 1'b1) busy_n++;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus_a.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus_a.busy); end
    checks++; if (bus_a.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus_a.done); end
    checks++; if (bus_a.Q !== 48'd0) begin errors++; $display("FAIL reset_q got %0h want 0", bus_a.Q); end
    checks++; if (bus_a.R !== 18'd0) begin errors++; $display("FAIL reset_r got %0h want 0", bus_a.R); end
    checks++; if (bus_a.dz !== 1'b0) begin errors++; $display("FAIL reset_dz got %b want 0", bus_a.dz); end
  endtask

  task automatic test_add_basic();
    int cyc, busy_n;
    launch(48'd100, 48'd4, 18'd8);
    checks++; if (bus_a.busy !== 1'b1) begin errors++; $display("FAIL basic_busy_start got %b want 1", bus_a.busy); end
    wait_done(cyc, busy_n);
    checks++; if (cyc != 48) begin errors++; $display("FAIL basic_latency got %0d want 48", cyc); end
    checks++; if (busy_n != 48) begin errors++; $display("FAIL basic_busy_len got %0d want 48", busy_n); end
    checks++; if (bus_a.Q !== 48'd12) begin errors++; $display("FAIL basic_q got %0h want c", bus_a.Q); end
    checks++; if (bus_a.R !== 18'd0) begin errors++; $display("FAIL basic_r got %0h want 0", bus_a.R); end
    checks++; if (bus_a.dz !== 1'b0) begin errors++; $display("FAIL basic_dz got %b want 0", bus_a.dz); end
    @(negedge clk);
    checks++; if (bus_a.done !== 1'b0) begin errors++; $display("FAIL basic_done_width got %b want 0", bus_a.done); end
    checks++; if (bus_a.Q !== 48'd12) begin errors++; $display("FAIL basic_q_hold got %0h want c", bus_a.Q); end
  endtask

  task automatic test_add_rem_and_sub();
    int cyc, busy_n;
    launch(48'd103, 48'd4, 18'd8);
    wait_done(cyc, busy_n);
    checks++; if (bus_a.Q !== 48'd12) begin errors++; $display("FAIL rem_q got %0h want c", bus_a.Q); end
    checks++; if (bus_a.R !== 18'd3) begin errors++; $display("FAIL rem_r got %0h want 3", bus_a.R); end
    launch(48'd50, 48'd10, 18'd6);
    wait_done(cyc, busy_n);
    checks++; if (bus_s.done !== 1'b1) begin errors++; $display("FAIL sub_done got %b want 1", bus_s.done); end
    checks++; if (bus_s.Q !== 48'd10) begin errors++; $display("FAIL sub_q got %0h want a", bus_s.Q); end
    checks++; if (bus_s.R !== 18'd0) begin errors++; $display("FAIL sub_r got %0h want 0", bus_s.R); end
    checks++; if (bus_a.Q !== 48'd6) begin errors++; $display("FAIL add40_q got %0h want 6", bus_a.Q); end
    checks++; if (bus_a.R !== 18'd4) begin errors++; $display("FAIL add40_r got %0h want 4", bus_a.R); end
  endtask

  task automatic test_wrap_max();
    int cyc, busy_n;
    launch(48'd0, 48'd1, 18'd3);
    wait_done(cyc, busy_n);
    checks++; if (bus_a.Q !== 48'h5555_5555_5555) begin errors++; $display("FAIL wrap_q got %0h want 555555555555", bus_a.Q); end
    checks++; if (bus_a.R !== 18'd0) begin errors++; $display("FAIL wrap_r got %0h want 0", bus_a.R); end
    launch(48'hFFFF_FFFF_FFFF, 48'd0, 18'd1);
    wait_done(cyc, busy_n);
    checks++; if (bus_a.Q !== 48'hFFFF_FFFF_FFFF) begin errors++; $display("FAIL max_q got %0h want ffffffffffff", bus_a.Q); end
    checks++; if (bus_a.R !== 18'd0) begin errors++; $display("FAIL max_r got %0h want 0", bus_a.R); end
    launch(48'h3FFFE, 48'd0, 18'h3FFFF);
    wait_done(cyc, busy_n);
    checks++; if (bus_a.Q !== 48'd0) begin errors++; $display("FAIL bmax_q got %0h want 0", bus_a.Q); end
    checks++; if (bus_a.R !== 18'h3FFFE) begin errors++; $display("FAIL bmax_r got %0h want 3fffe", bus_a.R); end
  endtask

  task automatic test_div_zero();
    int cyc, busy_n;
    launch(48'd77, 48'd0, 18'd0);
    wait_done(cyc, busy_n);
    checks++; if (cyc != 1) begin errors++; $display("FAIL dz_latency got %0d want 1", cyc); end
    checks++; if (busy_n != 1) begin errors++; $display("FAIL dz_busy_len got %0d want 1", busy_n); end
    checks++; if (bus_a.Q !== 48'hFFFF_FFFF_FFFF) begin errors++; $display("FAIL dz_q got %0h want ffffffffffff", bus_a.Q); end
    checks++; if (bus_a.R !== 18'd0) begin errors++; $display("FAIL dz_r got %0h want 0", bus_a.R); end
    checks++; if (bus_a.dz !== 1'b1) begin errors++; $display("FAIL dz_flag got %b want 1", bus_a.dz); end
    @(negedge clk);
    checks++; if (bus_a.done !== 1'b0) begin errors++; $display("FAIL dz_done_width got %b want 0", bus_a.done); end
    launch(48'd100, 48'd4, 18'd8);
    wait_done(cyc, busy_n);
    checks++; if (bus_a.dz !== 1'b0) begin errors++; $display("FAIL dz_clear got %b want 0", bus_a.dz); end
    checks++; if (bus_a.Q !== 48'd12) begin errors++; $display("FAIL dz_after_q got %0h want c", bus_a.Q); end
  endtask

  task automatic test_ignore_start();
    int cyc;
    launch(48'd103, 48'd4, 18'd8);
    cyc = 0;
    while (bus_a.done !== 1'b1 && cyc < 80) begin
      if (cyc == 20) drive(1'b1, 48'd1000, 48'd0, 18'd3);
      else if (cyc == 21) set_start(1'b0);
      @(negedge clk);
      cyc++;
    end
    checks++; if (cyc != 48) begin errors++; $display("FAIL ignore_latency got %0d want 48", cyc); end
    checks++; if (bus_a.Q !== 48'd12) begin errors++; $display("FAIL ignore_q got %0h want c", bus_a.Q); end
    checks++; if (bus_a.R !== 18'd3) begin errors++; $display("FAIL ignore_r got %0h want 3", bus_a.R); end
    @(negedge clk);
    checks++; if (bus_a.busy !== 1'b0) begin errors++; $display("FAIL ignore_no_restart got %b want 0", bus_a.busy); end
  endtask

  task automatic test_back_to_back();
    int t [3];
    int n;
    n = 0;
    @(negedge clk);
    drive(1'b1, 48'd100, 48'd4, 18'd8);
    for (int c = -1; c < 150; c++) begin
      @(negedge clk);
      if (bus_a.done === 1'b1 && n < 3) begin
        t[n] = c + 1;
        n++;
      end
    end
    set_start(1'b0);
    checks++; if (n != 3) begin errors++; $display("FAIL b2b_pulses got %0d want 3", n); end
    checks++; if (t[0] != 48) begin errors++; $display("FAIL b2b_first got %0d want 48", t[0]); end
    checks++; if (t[1] - t[0] != 49) begin errors++; $display("FAIL b2b_gap1 got %0d want 49", t[1] - t[0]); end
    checks++; if (t[2] - t[1] != 49) begin errors++; $display("FAIL b2b_gap2 got %0d want 49", t[2] - t[1]); end
    do_reset();
  endtask

  task automatic test_reset_mid();
    int cyc, busy_n, seen;
    launch(48'd100, 48'd4, 18'd8);
    wait_done(cyc, busy_n);
    launch(48'd103, 48'd4, 18'd8);
    for (int c = 0; c < 30; c++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (bus_a.busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b want 0", bus_a.busy); end
    checks++; if (bus_a.Q !== 48'd0) begin errors++; $display("FAIL rmid_q got %0h want 0", bus_a.Q); end
    checks++; if (bus_a.R !== 18'd0) begin errors++; $display("FAIL rmid_r got %0h want 0", bus_a.R); end
    seen = 0;
    for (int c = 0; c < 60; c++) begin
      if (bus_a.done === 1'b1) seen++;
      @(negedge clk);
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL rmid_no_done got %0d want 0", seen); end
    launch(48'd103, 48'd4, 18'd8);
    wait_done(cyc, busy_n);
    checks++; if (cyc != 48) begin errors++; $display("FAIL rmid_relaunch_latency got %0d want 48", cyc); end
    checks++; if (bus_a.Q !== 48'd12) begin errors++; $display("FAIL rmid_relaunch_q got %0h want c", bus_a.Q); end
    checks++; if (bus_a.R !== 18'd3) begin errors++; $display("FAIL rmid_relaunch_r got %0h want 3", bus_a.R); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    drive(1'b0, 48'd0, 48'd0, 18'd0);
    test_reset();
    test_add_basic();
    test_add_rem_and_sub();
    test_wrap_max();
    test_div_zero();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dsp_div_recover.md
# dsp_div_recover

Sequential restoring divider that reverses the DSP multiply-add datapath. Given a DSP result `P`, the `C` addend/subtrahend and the `B` multiplier, it recovers the `A`-side operand as a quotient and remainder: `Q = diff / B`, `R = diff % B`. It sits downstream of the DSP slice for self-check and calibration. It takes one start/done transaction at a time and produces one quotient bit per cycle.

## Interface
- `OPERATION`, default "ADD": DSP mode being inverted.
  - "ADD": `diff = P - C`.
  - "SUBTRACT": `diff = P + C`.
  - Both are modulo 2^48.
- `clk` input 1: single clock; all logic on its rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `start` input 1: request. Sampled only while `busy=0`.
- `P` input 48: DSP result operand.
- `C` input 48: DSP `C` operand.
- `B` input 18: divisor (the DSP `B` operand), unsigned.
- `busy` output 1: division in progress.
- `done` output 1: single-cycle pulse. `Q`, `R` and `dz` are valid when it is high.
- `Q` output 48: unsigned quotient, registered.
- `R` output 18: unsigned remainder, registered.
- `dz` output 1: divide-by-zero flag for the last completed transaction.

## Operation
- States:
  - IDLE: `start=1` and `B!=0` -> CALC. `start=1` and `B==0` -> DZERO.
  - CALC: 48 iterations, then -> IDLE with `done`.
  - DZERO: 1 cycle, then -> IDLE with `done`.
- Capture (edge where `start` is accepted):
  - `dvd = diff` (48-bit shift register).
  - `div = B`.
  - `rem = 0` (19 bits).
  - `cnt = 0` (6 bits).
  - `busy <= 1`.
- Iteration (each CALC edge):
  - `trial = {rem[17:0], dvd[47]} - {1'b0, div}`.
  - If `trial` is non-negative: `rem = trial`, quotient bit = 1.
  - Otherwise: `rem = {rem[17:0], dvd[47]}`, quotient bit = 0.
  - `dvd` shifts left, taking the quotient bit into its LSB; after 48 shifts `dvd` holds `Q`.
  - `cnt` increments.
- Completion (edge of iteration `cnt==47`): `Q <= final dvd`, `R <= rem[17:0]`, `dz <= 0`, `done <= 1`, `busy <= 0`.
- DZERO: `Q <= 48'hFFFF_FFFF_FFFF`, `R <= 0`, `dz <= 1`, `done <= 1`, `busy <= 0`.
- Width rules:
  - `R < B` always, so `R` fits in 18 bits.
  - `rem` carries one guard bit (19 bits) for the trial subtract.
  - Arithmetic on `diff` wraps silently modulo 2^48; there is no overflow flag.
- Outputs `Q`, `R` and `dz` hold their values until the next completion or reset.
- `start` while `busy=1` is ignored: no queueing, no error.
- `P`, `C` and `B` may change freely after the capture edge.

## Timing
- Reset (`rst=1` at a rising edge) returns to IDLE from any state, including mid-CALC, with the partial result discarded. Reset values:
  - `busy=0`, `done=0`.
  - `Q=0`, `R=0`, `dz=0`.
  - Internal `cnt`, `rem` and `dvd` cleared.
- Normal division, `start` accepted at edge t:
  - `busy=1` from t to t+48.
  - Iterations run at edges t+1 .. t+48.
  - `done=1`, with `Q` and `R` valid, for exactly the cycle after edge t+48.
- Divide by zero, `start` accepted at edge t:
  - `busy=1` for one cycle.
  - `done=1` in the cycle after edge t+1.
- Back-to-back operation:
  - `start` held high in the `done` cycle is accepted at that edge, since `busy=0`.
  - Throughput is one division per 49 cycles.
- `done` never lasts more than one cycle.
- If `rst` and `start` are both high at the same edge, `rst` wins.

## Test plan
- ADD mode, P=100, C=4, B=8, pulse `start` -> `busy` for 48 cycles; `done` at cycle 49 with Q=12, R=0, dz=0.
- ADD mode, P=103, C=4, B=8 -> Q=12, R=3. Then SUBTRACT build with P=50, C=10, B=6 -> Q=10, R=0.
- Wrap and maximum values in ADD mode:
  - P=0, C=1, B=3 -> Q=48'h5555_5555_5555, R=0.
  - P=48'hFFFF_FFFF_FFFF, C=0, B=1 -> Q=48'hFFFF_FFFF_FFFF, R=0.
  - B=18'h3FFFF with P=18'h3FFFE, C=0 -> Q=0, R=18'h3FFFE.
- Divide by zero: B=0, P=77, C=0 -> `done` two cycles after the `start` edge with Q=all ones, R=0, dz=1. A following valid op clears `dz` to 0.
- Protocol:
  - `start` pulsed again at cycle 20 of a division -> ignored; the first result is unchanged and arrives on time.
  - `start` held high continuously -> successive `done` pulses exactly 49 cycles apart.
- Reset mid-operation: `rst=1` for one edge at cycle 30 of a division -> `busy=0`, `Q=0`, `R=0`, and no `done` pulse. A new `start` afterwards completes normally with the full 48-cycle latency.
